rv_mem_supervisor: RTL and testbench
====================================

Name: rv_mem_supervisor

Overview:
- Parametrised successor to the fixed AXI-BRAM memory wrapper on the RV32I core's external memory port.
- Implements the memory as inferred block RAM behind the same split write-address / write-data / write-response and read-address / read-data channels.
- Adds configurable depth, width and read latency, decoupled write channels, response back-pressure, a bounded outstanding-read queue and out-of-range error reporting.

Parameters:
- MEM_ADDR_WIDTH, 32, byte-address width.
- MEM_DATA_WIDTH, 32, data width; must be a power of two and at least 8.
- MASK_WIDTH, MEM_DATA_WIDTH/8, byte-enable width.
- DEPTH_LOG2, 11, log2 of the number of memory words.
- READ_LATENCY, 1, number of RAM pipeline stages from read issue to queue entry; legal range 1..4.
- RQ_DEPTH, 4, maximum number of outstanding reads (pipeline plus response queue); power of two, at least 2.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- waen  in  1  write-address valid.
- waddr  in  MEM_ADDR_WIDTH  write byte address.
- wardy  out  1  write-address ready.
- wden  in  1  write-data valid.
- wdata  in  MEM_DATA_WIDTH  write data.
- wmask  in  MASK_WIDTH  byte enables.
- wdrdy  out  1  write-data ready.
- wbvld  out  1  write response valid.
- wberr  out  1  write response error; valid with wbvld.
- wbrdy  in  1  write response accepted.
- raen  in  1  read-address valid.
- raddr  in  MEM_ADDR_WIDTH  read byte address.
- rardy  out  1  read-address ready.
- rdata  out  MEM_DATA_WIDTH  read data.
- rderr  out  1  read error; valid with rdrdy.
- rdrdy  out  1  read data valid.
- rrdy  in  1  read data accepted.

Behaviour:
- Address decode:
  - OFS = log2(MASK_WIDTH).
  - Word index = addr[DEPTH_LOG2+OFS-1:OFS].
  - Low OFS bits are ignored.
  - Any nonzero bit at or above DEPTH_LOG2+OFS makes the access out of range.
- Reset (synchronous, active-high):
  - Clears both write holding registers, the read pipeline and the response queue.
  - Drives wardy=0, wdrdy=0, rardy=0, wbvld=0, wberr=0, rdrdy=0, rderr=0, rdata=0.
  - RAM contents are preserved.
  - Ready outputs rise in the first cycle after reset deasserts.
  - A reset mid-transaction drops every pending write and read; no response is issued.
- Write path:
  - One-entry address holding register (AH) and one-entry data holding register (DH).
  - wardy = !AH_full; wdrdy = !DH_full; both are registered and deasserted during reset.
  - Address and data may arrive in either order or in the same cycle.
  - Commit cycle: occurs when AH and DH are both full and the response slot is free (wbvld=0, or wbvld&&wbrdy this cycle).
    - In range: RAM bytes with wmask[i]=1 are written.
    - Out of range: no write occurs.
    - AH and DH clear.
    - Next cycle: wbvld=1, wberr=out-of-range.
  - Minimum latency is 2 cycles from the last of waen/wden to wbvld.
  - wbvld and wberr hold until wbrdy; only one write response is outstanding at a time.
  - wmask=0 in range still commits and responds with wberr=0.
- Read path:
  - Accept on raen&&rardy; rardy = (outstanding < RQ_DEPTH), where outstanding counts pipeline stages plus queue entries.
  - The accepted read traverses READ_LATENCY registered stages and then enters a FIFO of RQ_DEPTH entries.
  - rdrdy = FIFO not empty; rdata and rderr come from the FIFO head; pop on rdrdy&&rrdy.
  - Out-of-range reads return rdata=0 and rderr=1.
  - Minimum latency is READ_LATENCY+1 cycles from accept to rdrdy.
  - rdata holds stable while rdrdy&&!rrdy.
  - The outstanding counter updates for an accept and a pop in the same cycle with net change 0, so rardy stays high when at the limit.
  - With rrdy tied high, one read per cycle is sustained.
- Ordering and collisions:
  - Responses return in acceptance order.
  - Same-word read issue and write commit in the same cycle: the read returns the old data (read-first).
  - Reads and writes are otherwise independent; no cross-channel ordering is guaranteed beyond this rule.

Test Plan:
- Write/read round trip (DEPTH_LOG2=11, READ_LATENCY=1): waen+wden same cycle at addr 0x10, data 0xDEADBEEF, mask 0xF -> wbvld 2 cycles later, wberr=0; then read 0x10 -> rdrdy 2 cycles after accept, rdata=0xDEADBEEF, rderr=0.
- Data before address: wden with 0x11223344, mask 0b0101, then waen 3 cycles later to a word preloaded with 0xAABBCCDD -> wdrdy=0 until commit; read returns 0xAA22CC44.
- Response back-pressure: rrdy=0 while issuing 6 reads (RQ_DEPTH=4) -> exactly 4 accepted and rardy=0; raise rrdy -> 4 responses in order, then the remaining 2 are accepted; with wbrdy=0, a second write stalls with AH/DH full and no commit until wbrdy.
- Out of range: write and read at byte address 0x2000 (DEPTH_LOG2=11) -> wberr=1, RAM unchanged (word 0 still reads its prior value); read gives rdata=0, rderr=1.
- Collision: word 5 holds 0x1; the write of 0x2 commits in the same cycle a read of word 5 is accepted -> that read returns 0x1; the next read returns 0x2.
- Reset mid-operation: assert reset with 3 reads in flight and AH full -> no rdrdy/wbvld afterward, all outputs 0 during reset, readies 1 the cycle after, and previously written RAM data readable.

Source files
------------

// File: rtl/rv_mem_supervisor.sv
// Block-RAM memory behind split write (address/data/response) and read (address/data) channels.
// Write path uses one-entry holding registers; reads flow through a fixed-latency pipeline into a response FIFO.
module rv_mem_supervisor #(
  parameter int unsigned MEM_ADDR_WIDTH = 32,
  parameter int unsigned MEM_DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH     = MEM_DATA_WIDTH / 8,
  parameter int unsigned DEPTH_LOG2     = 11,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RQ_DEPTH       = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      waen,
  input  logic [MEM_ADDR_WIDTH-1:0] waddr,
  output logic                      wardy,
  input  logic                      wden,
  input  logic [MEM_DATA_WIDTH-1:0] wdata,
  input  logic [MASK_WIDTH-1:0]     wmask,
  output logic                      wdrdy,
  output logic                      wbvld,
  output logic                      wberr,
  input  logic                      wbrdy,
  input  logic                      raen,
  input  logic [MEM_ADDR_WIDTH-1:0] raddr,
  output logic                      rardy,
  output logic [MEM_DATA_WIDTH-1:0] rdata,
  output logic                      rderr,
  output logic                      rdrdy,
  input  logic                      rrdy
);
  localparam int unsigned OFS   = $clog2(MASK_WIDTH);
  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = $clog2(RQ_DEPTH);
  localparam int unsigned CW    = $clog2(RQ_DEPTH + 1);

  function automatic logic addr_oor(input logic [MEM_ADDR_WIDTH-1:0] a);
    return (a >> (DEPTH_LOG2 + OFS)) != '0;
  endfunction

  logic [MEM_DATA_WIDTH-1:0] mem [WORDS];

  // ---------------- write path ----------------
  logic                      ah_full_q, ah_full_d, dh_full_q, dh_full_d;
  logic [MEM_ADDR_WIDTH-1:0] ah_addr_q;
  logic [MEM_DATA_WIDTH-1:0] dh_data_q;
  logic [MASK_WIDTH-1:0]     dh_mask_q;
  logic                      wardy_q, wdrdy_q, wbvld_q, wbvld_d, wberr_q, wberr_d;
  logic                      commit, ah_oor;
  logic [DEPTH_LOG2-1:0]     ah_idx;

  assign commit = ah_full_q && dh_full_q && (!wbvld_q || wbrdy);
  assign ah_oor = addr_oor(ah_addr_q);
  assign ah_idx = ah_addr_q[DEPTH_LOG2+OFS-1:OFS];

  always_comb begin
    ah_full_d = ah_full_q;
    dh_full_d = dh_full_q;
    wbvld_d   = wbvld_q;
    wberr_d   = wberr_q;
    if (wbvld_q && wbrdy) begin
      wbvld_d = 1'b0;
      wberr_d = 1'b0;
    end
    // A commit may reload the response slot in the same cycle the old one is accepted.
    if (commit) begin
      ah_full_d = 1'b0;
      dh_full_d = 1'b0;
      wbvld_d   = 1'b1;
      wberr_d   = ah_oor;
    end
    if (waen && wardy_q) ah_full_d = 1'b1;
    if (wden && wdrdy_q) dh_full_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ah_full_q <= 1'b0;
      dh_full_q <= 1'b0;
      wardy_q   <= 1'b0;
      wdrdy_q   <= 1'b0;
      wbvld_q   <= 1'b0;
      wberr_q   <= 1'b0;
    end else begin
      ah_full_q <= ah_full_d;
      dh_full_q <= dh_full_d;
      wardy_q   <= !ah_full_d;
      wdrdy_q   <= !dh_full_d;
      wbvld_q   <= wbvld_d;
      wberr_q   <= wberr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (waen && wardy_q) ah_addr_q <= waddr;
    if (wden && wdrdy_q) begin
      dh_data_q <= wdata;
      dh_mask_q <= wmask;
    end
  end

  assign wardy = wardy_q;
  assign wdrdy = wdrdy_q;
  assign wbvld = wbvld_q;
  assign wberr = wberr_q;

  // ---------------- read path ----------------
  logic                      rd_acc, rd_oor, push, pop;
  logic [DEPTH_LOG2-1:0]     rd_idx;
  logic [READ_LATENCY-1:0]   pv_q;
  logic [MEM_DATA_WIDTH-1:0] pd_q [READ_LATENCY];
  logic                      pe_q [READ_LATENCY];
  logic [MEM_DATA_WIDTH:0]   fq_q [RQ_DEPTH];
  logic [PW-1:0]             wp_q, rp_q;
  logic [CW-1:0]             cnt_q, cnt_d, out_q, out_d;
  logic                      rardy_q;

  assign rd_acc = raen && rardy_q;
  assign rd_oor = addr_oor(raddr);
  assign rd_idx = raddr[DEPTH_LOG2+OFS-1:OFS];
  assign push   = pv_q[READ_LATENCY-1];
  assign rdrdy  = (cnt_q != '0);
  assign pop    = rdrdy && rrdy;

  // RAM and pipeline data share one process; nonblocking update gives read-first on collision.
  always_ff @(posedge clock) begin
    if (commit && !ah_oor) begin
      for (int unsigned b = 0; b < MASK_WIDTH; b++) begin
        if (dh_mask_q[b]) mem[ah_idx][b*8 +: 8] <= dh_data_q[b*8 +: 8];
      end
    end
    if (rd_acc) begin
      pd_q[0] <= rd_oor ? '0 : mem[rd_idx];
      pe_q[0] <= rd_oor;
    end
    for (int unsigned s = 1; s < READ_LATENCY; s++) begin
      pd_q[s] <= pd_q[s-1];
      pe_q[s] <= pe_q[s-1];
    end
    if (push) fq_q[wp_q] <= {pe_q[READ_LATENCY-1], pd_q[READ_LATENCY-1]};
  end

  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    case ({rd_acc, pop})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: ;
    endcase
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pv_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      rardy_q <= 1'b0;
    end else begin
      pv_q[0] <= rd_acc;
      for (int unsigned s = 1; s < READ_LATENCY; s++) pv_q[s] <= pv_q[s-1];
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_q + PW'(1);
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rardy_q <= (out_d < CW'(RQ_DEPTH));
    end
  end

  assign rardy = rardy_q;
  assign rdata = rdrdy ? fq_q[rp_q][MEM_DATA_WIDTH-1:0] : '0;
  assign rderr = rdrdy ? fq_q[rp_q][MEM_DATA_WIDTH]     : 1'b0;

endmodule

// File: tb/tb_rv_mem_supervisor.sv
// Directed bench for rv_mem_supervisor: a transaction-level memory model checks every
// handshake and ready each cycle, alongside hand-computed literal expectations.
module tb_rv_mem_supervisor;
  localparam int unsigned RQ = 4;

  logic        clock = 1'b0, reset = 1'b1;
  logic        waen = 1'b0, wden = 1'b0, wbrdy = 1'b1, raen = 1'b0, rrdy = 1'b1;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic [3:0]  wmask = '0;
  logic        wardy, wdrdy, wbvld, wberr, rardy, rderr, rdrdy;
  logic [31:0] rdata;

  int vectors = 0, miscompares = 0;

  always #5 clock = ~clock;

  rv_mem_supervisor #(
    .MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(32), .MASK_WIDTH(4),
    .DEPTH_LOG2(11), .READ_LATENCY(1), .RQ_DEPTH(RQ)
  ) dut (
    .clock(clock), .reset(reset),
    .waen(waen), .waddr(waddr), .wardy(wardy),
    .wden(wden), .wdata(wdata), .wmask(wmask), .wdrdy(wdrdy),
    .wbvld(wbvld), .wberr(wberr), .wbrdy(wbrdy),
    .raen(raen), .raddr(raddr), .rardy(rardy),
    .rdata(rdata), .rderr(rderr), .rdrdy(rdrdy), .rrdy(rrdy)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed { logic err; logic [31:0] data; } rsp_t;
  logic [31:0] mem_m [int unsigned];
  rsp_t        rq[$];
  rsp_t        rx_q[$];
  logic [31:0] aq[$];
  logic [35:0] dq[$];

  function automatic logic oor(input logic [31:0] a);
    return (a >> 13) != 0;
  endfunction

  function automatic rsp_t model_read(input logic [31:0] a);
    rsp_t r;
    if (oor(a)) begin
      r.err = 1'b1; r.data = '0;
    end else begin
      r.err = 1'b0;
      r.data = mem_m.exists(int'(a >> 2)) ? mem_m[int'(a >> 2)] : '0;
    end
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    if (oor(a)) return;
    w = mem_m.exists(int'(a >> 2)) ? mem_m[int'(a >> 2)] : '0;
    for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    mem_m[int'(a >> 2)] = w;
  endfunction

  logic        rst_prev = 1'b1, p_wbvld = 1'b0, p_wbrdy = 1'b0, p_hold_r = 1'b0, p_wberr = 1'b0, p_rderr = 1'b0;
  logic [31:0] p_rdata = '0;

  always @(negedge clock) begin
    logic [31:0] a;
    logic [35:0] d;
    rsp_t        e;
    if (rst_prev) begin
      check("reset_outputs", 64'({wardy, wdrdy, rardy, wbvld, wberr, rdrdy, rderr, rdata}), 64'(0));
    end else begin
      if (p_hold_r) check("rdata_hold", 64'({rdrdy, rderr, rdata}), 64'({1'b1, p_rderr, p_rdata}));
      if (p_wbvld && !p_wbrdy) check("wresp_hold", 64'({wbvld, wberr}), 64'({1'b1, p_wberr}));
      if (wbvld && (!p_wbvld || p_wbrdy)) begin
        check("wresp_pending", 64'(aq.size() > 0 && dq.size() > 0), 64'(1));
        if (aq.size() > 0 && dq.size() > 0) begin
          a = aq.pop_front();
          d = dq.pop_front();
          model_write(a, d[31:0], d[35:32]);
          check("wberr", 64'(wberr), 64'(oor(a)));
        end
      end
      check("wardy", 64'(wardy), 64'(aq.size() == 0));
      check("wdrdy", 64'(wdrdy), 64'(dq.size() == 0));
      check("rardy", 64'(rardy), 64'(rq.size() < RQ));
    end
    if (reset) begin
      rq.delete(); aq.delete(); dq.delete();
    end else begin
      if (waen && wardy) aq.push_back(waddr);
      if (wden && wdrdy) dq.push_back({wmask, wdata});
      if (raen && rardy) rq.push_back(model_read(raddr));
      if (rdrdy && rrdy) begin
        check("rresp_pending", 64'(rq.size() > 0), 64'(1));
        if (rq.size() > 0) begin
          e = rq.pop_front();
          check("rresp", 64'({rderr, rdata}), 64'({e.err, e.data}));
        end
        rx_q.push_back({rderr, rdata});
      end
    end
    p_hold_r = !reset && rdrdy && !rrdy;
    p_rdata  = rdata;
    p_rderr  = rderr;
    p_wbvld  = !reset && wbvld;
    p_wbrdy  = wbrdy;
    p_wberr  = wberr;
    rst_prev = reset;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic ga, gd;
    waen = 1'b1; waddr = a; wden = 1'b1; wdata = d; wmask = m;
    for (int n = 0; n < 50 && (waen || wden); n++) begin
      ga = wardy; gd = wdrdy;
      tick();
      if (ga) waen = 1'b0;
      if (gd) wden = 1'b0;
    end
    check("wr_accept_timeout", 64'({waen, wden}), 64'(0));
    waen = 1'b0; wden = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    logic g;
    raen = 1'b1; raddr = a;
    for (int n = 0; n < 50 && raen; n++) begin
      g = rardy;
      tick();
      if (g) raen = 1'b0;
    end
    check("rd_accept_timeout", 64'(raen), 64'(0));
    raen = 1'b0;
  endtask

  task automatic get_rsp(output rsp_t r);
    for (int n = 0; n < 50 && rx_q.size() == 0; n++) tick();
    check("rd_rsp_timeout", 64'(rx_q.size() > 0), 64'(1));
    r = (rx_q.size() > 0) ? rx_q.pop_front() : '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t r;
    int   acc, idx;
    logic g;

    idle(3);
    reset = 1'b0;
    check("ready_in_reset", 64'({wardy, wdrdy, rardy}), 64'(0));
    tick();
    check("ready_after_reset", 64'({wardy, wdrdy, rardy}), 64'(3'b111));

    // Round trip with same-cycle address and data.
    waen = 1'b1; waddr = 32'h10; wden = 1'b1; wdata = 32'hDEADBEEF; wmask = 4'hF;
    tick();
    waen = 1'b0; wden = 1'b0;
    check("wr_lat_early", 64'(wbvld), 64'(0));
    tick();
    check("wr_latency", 64'({wbvld, wberr}), 64'(2'b10));
    tick();
    raen = 1'b1; raddr = 32'h10;
    tick();
    raen = 1'b0;
    check("rd_lat_early", 64'(rdrdy), 64'(0));
    tick();
    check("rd_latency", 64'({rdrdy, rderr, rdata}), 64'({1'b1, 1'b0, 32'hDEADBEEF}));
    get_rsp(r);
    idle(2);

    // Data ahead of address, partial mask.
    do_write(32'h40, 32'hAABBCCDD, 4'hF);
    idle(3);
    wden = 1'b1; wdata = 32'h11223344; wmask = 4'b0101;
    tick();
    wden = 1'b0;
    check("dh_held_1", 64'(wdrdy), 64'(0));
    tick(); check("dh_held_2", 64'(wdrdy), 64'(0));
    tick(); check("dh_held_3", 64'(wdrdy), 64'(0));
    waen = 1'b1; waddr = 32'h40;
    tick();
    waen = 1'b0;
    check("dh_held_4", 64'(wdrdy), 64'(0));
    tick();
    check("late_addr_commit", 64'({wbvld, wberr, wdrdy}), 64'(3'b101));
    tick();
    do_read(32'h40);
    get_rsp(r);
    check("masked_merge", 64'(r), 64'({1'b0, 32'hAA22CC44}));

    // Read back-pressure with RQ_DEPTH outstanding.
    for (int i = 0; i < 6; i++) begin
      do_write(32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
      idle(2);
    end
    rrdy = 1'b0; acc = 0; idx = 0;
    raen = 1'b1; raddr = 32'h100;
    for (int n = 0; n < 10; n++) begin
      g = raen && rardy;
      tick();
      if (g) begin
        acc++; idx++;
        raddr = 32'h100 + 32'(4 * idx);
      end
    end
    check("rq_accepted", 64'(acc), 64'(4));
    check("rq_full_rardy", 64'(rardy), 64'(0));
    rrdy = 1'b1;
    for (int n = 0; n < 30 && idx < 6; n++) begin
      g = raen && rardy;
      tick();
      if (g) begin
        idx++;
        raddr = 32'h100 + 32'(4 * idx);
        if (idx == 6) raen = 1'b0;
      end
    end
    raen = 1'b0;
    check("rq_all_issued", 64'(idx), 64'(6));
    for (int i = 0; i < 6; i++) begin
      get_rsp(r);
      check("rq_order", 64'(r), 64'({1'b0, 32'hC0DE0000 + 32'(i)}));
    end

    // Write response back-pressure.
    wbrdy = 1'b0;
    do_write(32'h200, 32'h11111111, 4'hF);
    tick();
    do_write(32'h204, 32'h22222222, 4'hF);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("wr_stall", 64'({wardy, wdrdy, wbvld}), 64'(3'b001));
    end
    wbrdy = 1'b1;
    tick();
    check("wr_second_rsp", 64'(wbvld), 64'(1));
    tick();
    check("wr_rsp_drained", 64'(wbvld), 64'(0));
    do_read(32'h204);
    get_rsp(r);
    check("wr_stalled_data", 64'(r), 64'({1'b0, 32'h22222222}));

    // Out of range aliasing onto word 0 must not write.
    do_write(32'h0, 32'h5A5A5A5A, 4'hF);
    idle(3);
    do_write(32'h2000, 32'hFFFFFFFF, 4'hF);
    tick();
    check("oor_wberr", 64'({wbvld, wberr}), 64'(2'b11));
    idle(2);
    do_read(32'h0);
    get_rsp(r);
    check("oor_no_write", 64'(r), 64'({1'b0, 32'h5A5A5A5A}));
    do_read(32'h2000);
    get_rsp(r);
    check("oor_read", 64'(r), 64'({1'b1, 32'h0}));

    // Same-word read accept and write commit in one cycle.
    do_write(32'h14, 32'h1, 4'hF);
    idle(3);
    waen = 1'b1; waddr = 32'h14; wden = 1'b1; wdata = 32'h2; wmask = 4'hF;
    tick();
    waen = 1'b0; wden = 1'b0;
    raen = 1'b1; raddr = 32'h14;
    tick();
    tick();
    raen = 1'b0;
    get_rsp(r);
    check("collide_old", 64'(r), 64'({1'b0, 32'h1}));
    get_rsp(r);
    check("collide_new", 64'(r), 64'({1'b0, 32'h2}));
    idle(2);

    // Reset with reads in flight and address held.
    rrdy = 1'b0;
    do_read(32'h10);
    do_read(32'h40);
    do_read(32'h100);
    waen = 1'b1; waddr = 32'h14;
    tick();
    waen = 1'b0;
    check("ah_full_pre_reset", 64'(wardy), 64'(0));
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    tick();
    check("ready_after_mid_reset", 64'({wardy, wdrdy, rardy}), 64'(3'b111));
    rrdy = 1'b1;
    for (int n = 0; n < 8; n++) begin
      check("no_stale_rsp", 64'({rdrdy, wbvld}), 64'(0));
      tick();
    end
    check("rx_empty_after_reset", 64'(rx_q.size()), 64'(0));
    do_read(32'h14);
    get_rsp(r);
    check("ram_kept", 64'(r), 64'({1'b0, 32'h2}));

    idle(5);
    check("model_drained", 64'({rq.size() == 0, aq.size() == 0, dq.size() == 0}), 64'(3'b111));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
